// File: rtl/simd_pkg.sv
// Shared types and constants for the packed-SIMD execution unit:
// instruction layout, opcode/width/shift encodings and register bank reset image.
package simd_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_MUL   = 4'h2,
    OP_MAC   = 4'h3,
    OP_SHIFT = 4'h4,
    OP_AND   = 4'h8,
    OP_OR    = 4'h9,
    OP_XOR   = 4'hA,
    OP_NOT   = 4'hB
  } opcode_t;

  // 00 and 11 both mean full 32-bit lanes; they differ only as bank selects.
  typedef enum logic [1:0] {
    W_32  = 2'b00,
    W_8   = 2'b01,
    W_16  = 2'b10,
    W_32X = 2'b11
  } width_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROL = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    LOP_ADD   = 2'b00,
    LOP_SUB   = 2'b01,
    LOP_SHIFT = 2'b10
  } lane_op_t;

  typedef struct packed {
    opcode_t    opcode;
    width_t     width;
    shift_t     shtype;
    logic [1:0] rs2;
    logic [1:0] rs1;
  } instr_t;

  localparam int NREGS = 16;

  // Element i is the reset value of register Ri.
  localparam logic [NREGS-1:0][31:0] REG_INIT = {
    32'h0000_0001, 32'h8000_0000, 32'h0000_0005, 32'h0000_0003,
    32'h0001_0001, 32'h8000_7FFF, 32'h0006_0001, 32'h0005_1000,
    32'h0000_0001, 32'hFFFF_FFFF, 32'h0102_0380, 32'h1020_3080,
    32'hFFFF_FFFF, 32'h0000_FF00, 32'h0000_0F0F, 32'h0000_00F0
  };

endpackage

// File: rtl/simd_if.sv
// Instruction/result bundle of the SIMD unit; master drives instructions.
interface simd_if;
  logic [11:0] instruction;
  logic [31:0] outputvalue;

  modport master (output instruction, input outputvalue);
  modport slave  (input instruction, output outputvalue);
endinterface

// File: rtl/simd_lane_alu.sv
// Lane-partitioned add/sub/shift. All three lane widths are computed in
// parallel and the requested width is selected at the end.
module simd_lane_alu
  import simd_pkg::*;
(
  input  width_t      width,
  input  lane_op_t    op,
  input  shift_t      shtype,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [2:0][31:0] y_w;

  for (genvar wi = 0; wi < 3; wi++) begin : g_width
    localparam int LW = 8 << wi;
    localparam int NL = 32 / LW;
    localparam int AW = $clog2(LW);

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      logic [LW-1:0]   la;
      logic [LW-1:0]   lb;
      logic [LW-1:0]   res;
      logic [AW-1:0]   amt;
      logic [2*LW-1:0] rot;

      assign la  = a[gi*LW +: LW];
      assign lb  = b[gi*LW +: LW];
      assign amt = lb[AW-1:0];
      // Upper half of the doubled lane shifted left is the rotate-left result.
      assign rot = {la, la} << amt;

      always_comb begin
        res = la + lb;
        case (op)
          LOP_SUB: res = la - lb;
          LOP_SHIFT: begin
            case (shtype)
              SH_LSL:  res = la << amt;
              SH_LSR:  res = la >> amt;
              SH_ASR:  res = $signed(la) >>> amt;
              default: res = rot[2*LW-1:LW];
            endcase
          end
          default: ;
        endcase
      end

      assign y_w[wi][gi*LW +: LW] = res;
    end
  end

  always_comb begin
    case (width)
      W_8:     y = y_w[0];
      W_16:    y = y_w[1];
      default: y = y_w[2];
    endcase
  end

endmodule

// File: rtl/simd.sv
// Packed-SIMD execution unit: read-only register bank, lane ALU, multiplier,
// MAC accumulator, bitwise logic and a one-cycle registered result.
module simd
  import simd_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  simd_if.slave bus
);

  instr_t      ins;
  logic [31:0] bank_reg [NREGS];
  logic [31:0] opa;
  logic [31:0] opb;
  lane_op_t    lane_op;
  logic [31:0] lane_y;
  logic [15:0] p8_lo;
  logic [15:0] p8_hi;
  logic [31:0] p16;
  logic [31:0] p32;
  logic [31:0] mul_res;
  logic [31:0] mac_sum;
  logic [31:0] result_next;
  logic [31:0] result_reg;
  logic [31:0] acc_next;
  logic [31:0] acc_reg;

  assign ins = instr_t'(bus.instruction);

  // Bank contents only ever come from the reset image; no write port exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        bank_reg[i] <= REG_INIT[i];
      end
    end
  end

  assign opa = bank_reg[{ins.width, ins.rs1}];
  assign opb = bank_reg[{ins.width, ins.rs2}];

  always_comb begin
    case (ins.opcode)
      OP_SUB:   lane_op = LOP_SUB;
      OP_SHIFT: lane_op = LOP_SHIFT;
      default:  lane_op = LOP_ADD;
    endcase
  end

  simd_lane_alu u_lane_alu (
    .width  (ins.width),
    .op     (lane_op),
    .shtype (ins.shtype),
    .a      (opa),
    .b      (opb),
    .y      (lane_y)
  );

  assign p8_lo = {8'd0, opa[7:0]} * {8'd0, opb[7:0]};
  assign p8_hi = {8'd0, opa[15:8]} * {8'd0, opb[15:8]};
  assign p16   = {16'd0, opa[15:0]} * {16'd0, opb[15:0]};
  assign p32   = opa * opb;

  always_comb begin
    case (ins.width)
      W_8:     mul_res = {p8_hi, p8_lo};
      W_16:    mul_res = p16;
      default: mul_res = p32;
    endcase
  end

  assign mac_sum = acc_reg + mul_res;

  always_comb begin
    result_next = '0;
    acc_next    = acc_reg;
    case (ins.opcode)
      OP_ADD, OP_SUB, OP_SHIFT: result_next = lane_y;
      OP_MUL: result_next = mul_res;
      OP_MAC: begin
        result_next = mac_sum;
        acc_next    = mac_sum;
      end
      OP_AND:  result_next = opa & opb;
      OP_OR:   result_next = opa | opb;
      OP_XOR:  result_next = opa ^ opb;
      OP_NOT:  result_next = ~opa;
      default: result_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      acc_reg    <= '0;
    end else begin
      result_reg <= result_next;
      acc_reg    <= acc_next;
    end
  end

  assign bus.outputvalue = result_reg;

endmodule

// File: tb/tb_simd.sv
// Self-checking bench for simd: directed vectors with fixed expected results,
// then random instructions against an arithmetic reference model.
module tb_simd;

  logic clk = 1'b0;
  logic rst;

  simd_if bus ();

  simd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] regs [16] = '{
    32'h0000_00F0, 32'h0000_0F0F, 32'h0000_FF00, 32'hFFFF_FFFF,
    32'h1020_3080, 32'h0102_0380, 32'hFFFF_FFFF, 32'h0000_0001,
    32'h0005_1000, 32'h0006_0001, 32'h8000_7FFF, 32'h0001_0001,
    32'h0000_0003, 32'h0000_0005, 32'h8000_0000, 32'h0000_0001
  };

  logic [31:0] m_acc = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s out=%08h", tag, got);
    end
  endtask

  // Per-lane arithmetic on n-bit lanes, done with plain integer math.
  function automatic logic [31:0] lanes(input logic [3:0] op, input int n, input logic [1:0] sh,
                                         input logic [31:0] a, input logic [31:0] b);
    longint unsigned modv, x, y, v;
    longint sx;
    int s;
    logic [31:0] r;
    modv = 64'd1 << n;
    r = 32'd0;
    for (int k = 0; k < 32 / n; k++) begin
      x = (longint'(a) >> (k * n)) % modv;
      y = (longint'(b) >> (k * n)) % modv;
      s = int'(y % longint'(n));
      v = 0;
      case (op)
        4'h0: v = (x + y) % modv;
        4'h1: v = (x + modv - y) % modv;
        default: begin
          case (sh)
            2'd0: v = (x << s) % modv;
            2'd1: v = x >> s;
            2'd2: begin
              sx = (x >= modv / 2) ? longint'(x) - longint'(modv) : longint'(x);
              v = longint'(sx >>> s) % modv;
              if (sx < 0 && v != 0) v = v;
              v = (sx >>> s) < 0 ? longint'(modv) + (sx >>> s) : longint'(sx >>> s);
            end
            default: v = ((x << s) | (x >> (n - s))) % modv;
          endcase
        end
      endcase
      r = r | (32'(v) << (k * n));
    end
    return r;
  endfunction

  task automatic model(input logic [11:0] ins, output logic [31:0] res);
    logic [3:0] op;
    logic [1:0] w;
    int n;
    logic [31:0] a, b, mulv;
    longint unsigned pa, pb;
    op = ins[11:8];
    w  = ins[7:6];
    n  = (w == 2'd1) ? 8 : (w == 2'd2) ? 16 : 32;
    a  = regs[{w, ins[1:0]}];
    b  = regs[{w, ins[3:2]}];
    if (n == 8) begin
      mulv = (32'(a[15:8]) * 32'(b[15:8])) * 32'd65536 + 32'(a[7:0]) * 32'(b[7:0]);
    end else if (n == 16) begin
      mulv = 32'(a[15:0]) * 32'(b[15:0]);
    end else begin
      pa = longint'(a);
      pb = longint'(b);
      mulv = 32'((pa * pb) % (64'd1 << 32));
    end
    case (op)
      4'h0, 4'h1, 4'h4: res = lanes(op, n, ins[5:4], a, b);
      4'h2: res = mulv;
      4'h3: begin
        m_acc = m_acc + mulv;
        res = m_acc;
      end
      4'h8: res = a & b;
      4'h9: res = a | b;
      4'hA: res = a ^ b;
      4'hB: res = ~a;
      default: res = 32'd0;
    endcase
  endtask

  task automatic step(input logic [11:0] ins, input logic r, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    bus.instruction = ins;
    rst = r;
    if (r) begin
      exp = 32'd0;
      m_acc = 32'd0;
    end else begin
      model(ins, exp);
    end
    @(posedge clk);
    #1;
    check($sformatf("%s ins=%03h rst=%0d", tag, ins, r), bus.outputvalue, exp);
  endtask

  task automatic dstep(input logic [11:0] ins, input logic r, input string tag, input logic [31:0] k);
    step(ins, r, tag);
    check({tag, " fixed"}, bus.outputvalue, k);
  endtask

  localparam logic [11:0] I_MAC8 = 12'b0011_01_00_01_00;

  initial begin
    logic [3:0]  op;
    logic [31:0] rnd;
    logic [3:0]  ops [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
    logic        r;

    rst = 1'b1;
    bus.instruction = 12'd0;

    dstep(12'd0, 1'b1, "reset0", 32'h0000_0000);
    dstep(12'hFFF, 1'b1, "reset1", 32'h0000_0000);
    dstep(12'b0000_01_00_01_00, 1'b0, "add8",  32'h1122_3300);
    dstep(12'b0001_10_00_01_00, 1'b0, "sub16", 32'hFFFF_0FFF);
    dstep(12'b0010_01_00_01_00, 1'b0, "mul8",  32'h0090_4000);
    dstep(I_MAC8, 1'b0, "mac1", 32'h0090_4000);
    dstep(I_MAC8, 1'b0, "mac2", 32'h0120_8000);
    dstep(I_MAC8, 1'b1, "rst_prio", 32'h0000_0000);
    dstep(I_MAC8, 1'b0, "mac_after_rst", 32'h0090_4000);
    dstep(12'b0100_01_10_01_00, 1'b0, "sra8", 32'h0808_0680);
    dstep(12'b1000_00_00_10_01, 1'b0, "and", 32'h0000_0F00);
    dstep(12'b1001_00_00_10_01, 1'b0, "or",  32'h0000_FF0F);
    dstep(12'b1010_00_00_10_01, 1'b0, "xor", 32'h0000_F00F);
    dstep(12'b1011_00_00_00_01, 1'b0, "not", 32'hFFFF_F0F0);
    dstep(12'b0101_00_00_00_00, 1'b0, "rsvd", 32'h0000_0000);
    dstep(I_MAC8, 1'b0, "mac_keep", 32'h0120_8000);

    for (int i = 0; i < 400; i++) begin
      rnd = $urandom();
      if (rnd[31:29] == 3'd0) op = rnd[11:8];
      else op = ops[$urandom_range(0, 8)];
      r = ($urandom_range(0, 39) == 0);
      step({op, rnd[7:0]}, r, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
